// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the FP datapath blocks (adder, converters, multiplier).
package fp_pkg;

  localparam int unsigned FP32_W      = 32;
  localparam int unsigned FP32_EXP_W  = 8;
  localparam int unsigned FP32_FRAC_W = 23;
  localparam int unsigned FP32_SIG_W  = FP32_FRAC_W + 1;
  localparam int unsigned FP32_BIAS   = 127;
  localparam logic [FP32_EXP_W-1:0] FP32_EXP_MAX = '1;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_FRAC_W-1:0] frac;
  } fp32_t;

  // Round-to-nearest-even increment decision.
  function automatic logic rne_inc(input logic guard, input logic sticky, input logic lsb);
    return guard & (sticky | lsb);
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational FP32 field split and classification; denormals collapse to FP_ZERO.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [FP32_W-1:0]     fp,
  output logic                  sign_c,
  output logic [FP32_EXP_W-1:0] exp_c,
  output logic [FP32_SIG_W-1:0] sig_c,
  output fp_class_e             cls_c
);

  fp32_t f;

  assign f      = fp32_t'(fp);
  assign sign_c = f.sign;
  assign exp_c  = f.exp;
  assign sig_c  = {(f.exp != '0), f.frac};

  always_comb begin
    cls_c = FP_NORM;
    if (f.exp == FP32_EXP_MAX) begin
      cls_c = (f.frac != '0) ? FP_NAN : FP_INF;
    end else if (f.exp == '0) begin
      cls_c = FP_ZERO;
    end
  end

endmodule

// File: rtl/fp32_to_fixed.sv
// Three-stage FP32 -> signed fixed-point converter: unpack, shift/round (RNE), sign/saturate.
module fp32_to_fixed
  import fp_pkg::*;
#(
  parameter int unsigned PRECISION = 32,
  parameter int unsigned EXPONENT  = 8,
  parameter int unsigned FRACTION  = 23,
  parameter int unsigned INT_W     = 32,
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PRECISION-1:0] fp_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INT_W-1:0]     int_out,
  output logic                 overflow,
  output logic                 invalid
);

  localparam int unsigned BIAS    = (1 << (EXPONENT - 1)) - 1;
  localparam int unsigned SH_OFS  = BIAS + FRACTION - FRAC_BITS;
  localparam int unsigned SH_W    = 10;
  localparam int unsigned MAG_W   = 64;
  localparam int unsigned LSH_MAX = MAG_W - FP32_SIG_W;
  localparam int unsigned RND_W   = FP32_SIG_W + 2;
  localparam int unsigned WIDE_W  = FP32_SIG_W + RND_W;

  localparam logic [MAG_W-1:0] POS_LIM = (MAG_W'(1) << (INT_W - 1)) - MAG_W'(1);
  localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(1) << (INT_W - 1);
  localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en && reset_n;

  // S1 combinational: field split and signed shift distance
  logic                  u_sign;
  logic [FP32_EXP_W-1:0] u_exp;
  logic [FP32_SIG_W-1:0] u_sig;
  fp_class_e             u_cls;
  logic signed [SH_W-1:0] sh_c;

  fp_unpack u_unpack (
    .fp     (fp_in),
    .sign_c (u_sign),
    .exp_c  (u_exp),
    .sig_c  (u_sig),
    .cls_c  (u_cls)
  );

  assign sh_c = SH_W'(u_exp) - SH_W'(SH_OFS);

  // Stage registers
  logic                   s1_v, s1_sign;
  fp_class_e              s1_cls;
  logic [FP32_SIG_W-1:0]  s1_sig;
  logic signed [SH_W-1:0] s1_sh;

  logic                   s2_v, s2_sign, s2_big;
  fp_class_e              s2_cls;
  logic [MAG_W-1:0]       s2_mag;

  // S2 combinational: align significand, round right shifts to nearest even
  logic [MAG_W-1:0]  mag_c;
  logic              big_c;
  logic [SH_W-1:0]   neg_c;
  logic [SH_W-1:0]   rsh_c;
  logic [WIDE_W-1:0] wide_c;

  always_comb begin
    mag_c  = '0;
    big_c  = 1'b0;
    neg_c  = '0;
    rsh_c  = '0;
    wide_c = '0;
    if (!s1_sh[SH_W-1]) begin
      if (s1_sh[SH_W-2:0] > (SH_W-1)'(LSH_MAX)) begin
        big_c = 1'b1;
      end else begin
        mag_c = MAG_W'(s1_sig) << s1_sh[5:0];
      end
    end else begin
      // Distances past RND_W behave identically: value 0, guard 0, sticky 1.
      neg_c  = -s1_sh;
      rsh_c  = (neg_c > SH_W'(RND_W)) ? SH_W'(RND_W) : neg_c;
      wide_c = {s1_sig, RND_W'(0)} >> rsh_c;
      mag_c  = MAG_W'(wide_c[WIDE_W-1:RND_W])
             + MAG_W'(rne_inc(wide_c[RND_W-1], |wide_c[RND_W-2:0], wide_c[RND_W]));
    end
  end

  // S3 combinational: apply sign, saturate, map specials
  logic [INT_W-1:0] res_c;
  logic             ovf_c;
  logic             inv_c;

  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    inv_c = 1'b0;
    unique case (s2_cls)
      FP_NAN: inv_c = 1'b1;
      FP_INF: begin
        ovf_c = 1'b1;
        res_c = s2_sign ? INT_MIN : INT_MAX;
      end
      FP_NORM: begin
        if (s2_sign) begin
          if (s2_big || (s2_mag > NEG_LIM)) begin
            ovf_c = 1'b1;
            res_c = INT_MIN;
          end else begin
            res_c = INT_W'(0) - s2_mag[INT_W-1:0];
          end
        end else begin
          if (s2_big || (s2_mag > POS_LIM)) begin
            ovf_c = 1'b1;
            res_c = INT_MAX;
          end else begin
            res_c = s2_mag[INT_W-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  // Pipeline advance; every stage holds while the output is stalled
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_v      <= 1'b0;
      s1_sign   <= 1'b0;
      s1_cls    <= FP_ZERO;
      s1_sig    <= '0;
      s1_sh     <= '0;
      s2_v      <= 1'b0;
      s2_sign   <= 1'b0;
      s2_cls    <= FP_ZERO;
      s2_mag    <= '0;
      s2_big    <= 1'b0;
      out_valid <= 1'b0;
      int_out   <= '0;
      overflow  <= 1'b0;
      invalid   <= 1'b0;
    end else if (en) begin
      s1_v      <= in_valid;
      s1_sign   <= u_sign;
      s1_cls    <= u_cls;
      s1_sig    <= u_sig;
      s1_sh     <= sh_c;
      s2_v      <= s1_v;
      s2_sign   <= s1_sign;
      s2_cls    <= s1_cls;
      s2_mag    <= mag_c;
      s2_big    <= big_c;
      out_valid <= s2_v;
      int_out   <= res_c;
      overflow  <= s2_v & ovf_c;
      invalid   <= s2_v & inv_c;
    end
  end

endmodule
